approx_mul_rr_scheduler: RTL and testbench

//  Shares one 2-stage pipelined unsigned 8x8 multiplier among NREQ requesters using round-robin arbitration.

---
 rtl/approx_mul_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/approx_mul_rr_scheduler.sv | 98 +++++++++
 tb/tb_approx_mul_rr_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mul_pkg.sv
// Shared types and arithmetic for the round-robin scheduled approximate multiplier.
package approx_mul_pkg;

    localparam int unsigned OP_W  = 8;
    localparam int unsigned RES_W = 16;

    typedef struct packed {
        logic [OP_W-1:0] x;
        logic [OP_W-1:0] y;
        logic            exact;
    } mul_op_t;

    // l=2 truncated-exchange product: the two low x bits are dropped except
    // for the carries they would contribute at weight 2^8.
    function automatic logic [RES_W-1:0] approx_l2_mul(input logic [OP_W-1:0] x,
                                                       input logic [OP_W-1:0] y);
        logic [RES_W-1:0] p;
        logic [RES_W-1:0] c;
        p = RES_W'(y) * RES_W'(x[7:2]);
        c = RES_W'((x[0] & y[7]) | (x[1] & y[6])) + RES_W'(x[1] & y[7]);
        return (p << 2) + (c << 8);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from req and the pointer, plus the pointer register.
module rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           en,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id
);

    logic [IDW-1:0] ptr;
    logic           found;
    int unsigned    idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                grant_id = IDW'(idx);
            end
        end
        if (en && found) begin
            grant[grant_id] = 1'b1;
        end
    end

    // A grant always implies a transfer, since only valid requesters are granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (32'(grant_id) == N - 1) ? '0 : grant_id + IDW'(1);
        end
    end

endmodule

// File: rtl/approx_mul_rr_scheduler.sv
// Shares one 2-stage 8x8 multiplier (exact or l=2 approximate) among NREQ requesters.
module approx_mul_rr_scheduler
    import approx_mul_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_x,
    input  logic [NREQ*OP_W-1:0] req_y,
    input  logic [NREQ-1:0]      req_exact,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [RES_W-1:0]     res_z,
    output logic [IDW-1:0]       res_id,
    output logic                 res_exact,
    output logic                 busy
);

    logic             s1_v;
    mul_op_t          s1_op;
    logic [IDW-1:0]   s1_id;
    logic             s2_v;
    logic [RES_W-1:0] s2_z;
    logic [IDW-1:0]   s2_id;
    logic             s2_exact;

    logic             adv1;
    logic             adv2;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;
    mul_op_t          in_op;
    logic [RES_W-1:0] mul_z;

    assign adv2 = !s2_v || res_ready;
    assign adv1 = !s1_v || adv2;

    // Reset also masks the combinational accept so every output reads 0 during reset.
    rr_arbiter #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .en       (adv1 && !rst),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = grant;

    always_comb begin
        in_op.x     = req_x[32'(grant_id)*OP_W +: OP_W];
        in_op.y     = req_y[32'(grant_id)*OP_W +: OP_W];
        in_op.exact = req_exact[grant_id];
        mul_z       = s1_op.exact ? RES_W'(s1_op.x) * RES_W'(s1_op.y)
                                  : approx_l2_mul(s1_op.x, s1_op.y);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_op    <= '0;
            s1_id    <= '0;
            s2_v     <= 1'b0;
            s2_z     <= '0;
            s2_id    <= '0;
            s2_exact <= 1'b0;
        end else begin
            if (adv2) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_z     <= mul_z;
                    s2_id    <= s1_id;
                    s2_exact <= s1_op.exact;
                end
            end
            if (adv1) begin
                s1_v <= |grant;
                if (|grant) begin
                    s1_op <= in_op;
                    s1_id <= grant_id;
                end
            end
        end
    end

    assign res_valid = s2_v;
    assign res_z     = s2_z;
    assign res_id    = s2_id;
    assign res_exact = s2_exact;
    assign busy      = s1_v || s2_v;

endmodule

// File: tb/tb_approx_mul_rr_scheduler.sv
// Scoreboard bench for approx_mul_rr_scheduler with a queue-level reference model.
module tb_approx_mul_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic [3:0]  req_exact;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_z;
    logic [1:0]  res_id;
    logic        res_exact;
    logic        busy;

    typedef struct {
        int z;
        int id;
        int ex;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    approx_mul_rr_scheduler #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_exact (req_exact),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_z     (res_z),
        .res_id    (res_id),
        .res_exact (res_exact),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference product from the arithmetic rules, in plain integers.
    function automatic int model_z(input int x, input int y, input int ex);
        int b0, b1, y6, y7;
        if (ex != 0) return x * y;
        b0 = x % 2;
        b1 = (x / 2) % 2;
        y6 = (y / 64) % 2;
        y7 = (y / 128) % 2;
        return (x / 4) * y * 4 + 256 * ((b0 & y7) | (b1 & y6)) + 256 * (b1 & y7);
    endfunction

    // Request-side model: round-robin pointer and in-flight count.
    int c_m = 0;
    int ptr_m = 0;
    initial forever begin
        logic [3:0] er;
        int g;
        exp_t e;
        @(negedge clk);
        if (rst) begin
            c_m = 0;
            ptr_m = 0;
        end else begin
            er = 4'b0;
            g = -1;
            if (c_m < 2 || res_ready) begin
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && req_valid[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
                end
            end
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", int'(req_ready), int'(er));
            if (g >= 0) begin
                e.z  = model_z(int'(req_x[8*g +: 8]), int'(req_y[8*g +: 8]), int'(req_exact[g]));
                e.id = g;
                e.ex = int'(req_exact[g]);
                sb.push_back(e);
                ptr_m = (g + 1) % 4;
            end
            c_m = c_m + ((g >= 0) ? 1 : 0) - ((res_valid && res_ready) ? 1 : 0);
        end
    end

    // Result monitor: ordering, values and stability under backpressure.
    initial forever begin
        bit          hold;
        logic [15:0] hz;
        logic [1:0]  hid;
        logic        hex;
        exp_t        e;
        @(negedge clk);
        if (rst) begin
            sb.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", int'(res_valid), 1);
                chk("hold_z", int'(res_z), int'(hz));
                chk("hold_id", int'(res_id), int'(hid));
                chk("hold_exact", int'(res_exact), int'(hex));
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=z%0d/id%0d required=none", res_z, res_id);
                end else begin
                    e = sb.pop_front();
                    chk("res_z", int'(res_z), e.z);
                    chk("res_id", int'(res_id), e.id);
                    chk("res_exact", int'(res_exact), e.ex);
                end
            end
            hold = res_valid && !res_ready;
            hz   = res_z;
            hid  = res_id;
            hex  = res_exact;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        if (busy) chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic run_one(input int i, input int x, input int y, input int ex, input int expz);
        int n = 0;
        wait_idle();
        req_valid = 4'b0;
        req_valid[i] = 1'b1;
        req_x[8*i +: 8] = 8'(x);
        req_y[8*i +: 8] = 8'(y);
        req_exact[i] = ex[0];
        @(negedge clk);
        while (!req_ready[i] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("direct_accept", int'(req_ready[i]), 1);
        tick();
        req_valid = 4'b0;
        @(negedge clk);
        chk("direct_latency_early", int'(res_valid), 0);
        @(negedge clk);
        chk("direct_valid", int'(res_valid), 1);
        chk("direct_z", int'(res_z), expz);
        chk("direct_id", int'(res_id), i);
        chk("direct_exact", int'(res_exact), ex);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $finish;
    end

    initial begin
        int acc;
        rst = 1'b1;
        req_valid = 4'b0;
        req_x = '0;
        req_y = '0;
        req_exact = 4'b0;
        res_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_res_valid", int'(res_valid), 0);
        chk("idle_busy", int'(busy), 0);

        // Round-robin rotation with every requester asserting.
        tick();
        req_valid = 4'hf;
        req_x = $urandom;
        req_y = $urandom;
        req_exact = 4'($urandom);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_grant", int'(req_ready), 1 << (k % 4));
            if (k >= 2) begin
                chk("rr_throughput", int'(res_valid), 1);
                chk("rr_res_id", int'(res_id), (k - 2) % 4);
            end
            tick();
            req_x = $urandom;
            req_y = $urandom;
            req_exact = 4'($urandom);
        end
        req_valid = 4'b0;
        wait_idle();

        run_one(0, 255, 255, 0, 64772);
        run_one(0, 255, 255, 1, 65025);
        run_one(1, 3, 128, 0, 512);
        run_one(2, 3, 128, 1, 384);
        run_one(3, 1, 64, 0, 0);
        run_one(1, 4, 10, 0, 40);
        run_one(0, 4, 10, 1, 40);

        // Backpressure from an empty pipe: two accepts fill S1 and S2.
        wait_idle();
        res_ready = 1'b0;
        req_valid = 4'hf;
        req_x = $urandom;
        req_y = $urandom;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            acc += $countones(req_valid & req_ready);
            tick();
        end
        chk("bp_accepts", acc, 2);
        @(negedge clk);
        chk("bp_req_ready", int'(req_ready), 0);
        tick();
        res_ready = 1'b1;
        req_valid = 4'b0;
        wait_idle();
        chk("bp_drained", sb.size(), 0);

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 600; k++) begin
            tick();
            req_valid = 4'($urandom);
            req_x = $urandom;
            req_y = $urandom;
            req_exact = 4'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        req_valid = 4'b0;
        res_ready = 1'b1;
        wait_idle();
        chk("rand_drained", sb.size(), 0);

        // Reset with both stages full.
        req_valid = 4'hf;
        res_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("full_busy", int'(busy), 1);
        chk("full_res_valid", int'(res_valid), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_res_valid", int'(res_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_req_ready", int'(req_ready), 0);
        repeat (2) tick();
        rst = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", int'(req_ready), 1);
        tick();
        req_valid = 4'b0;
        wait_idle();
        chk("final_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
